// File: rtl/b2_serial_adder.sv
// Bit-serial x + y + cin over one reused full-adder slice, LSB first; N compute cycles per add.
// soc/eoc four-phase handshake: eoc low while busy, result held in s/cout until the next accepted soc.

module b2_halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic cout
);
  assign s    = a ^ b;
  assign cout = a & b;
endmodule

module b2_serial_adder #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         soc,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         eoc
);
  localparam int CW = ($clog2(N + 1) < 1) ? 1 : $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  xr, yr, sr;
  logic          c;
  logic [CW-1:0] cnt;
  logic          ha0_s, ha0_c, ha1_s, ha1_c;
  logic          sum_bit, carry;
  logic          last;

  b2_halfadder ha0 (.a(xr[0]), .b(yr[0]), .s(ha0_s), .cout(ha0_c));
  b2_halfadder ha1 (.a(ha0_s), .b(c),     .s(ha1_s), .cout(ha1_c));

  assign sum_bit = ha1_s;
  assign carry   = ha0_c | ha1_c;
  assign last    = (cnt == CW'(1));

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = soc ? S_CALC : S_IDLE;
      S_CALC:  state_nxt = last ? S_WAIT : S_CALC;
      S_WAIT:  state_nxt = soc ? S_WAIT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Any state other than S_CALC, including illegal encodings, reads as idle/valid.
  always_comb begin
    eoc = 1'b1;
    if (state == S_CALC) eoc = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      xr   <= '0;
      yr   <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sr   <= '0;
      cout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (soc) begin
            xr  <= x;
            yr  <= y;
            c   <= cin;
            cnt <= CW'(N);
          end
        end
        S_CALC: begin
          // Shift form instead of a concatenation so N=1 stays legal.
          sr  <= (sr >> 1) | (N'(sum_bit) << (N - 1));
          xr  <= xr >> 1;
          yr  <= yr >> 1;
          c   <= carry;
          cnt <= cnt - CW'(1);
          if (last) cout <= carry;
        end
        default: ;
      endcase
    end
  end

  assign s = sr;

endmodule

// File: tb/tb_b2_serial_adder.sv
// Directed-vector bench for b2_serial_adder (N=8) with hand-computed sums.
module tb_b2_serial_adder;
  localparam int N = 8;

  logic         clock = 1'b0;
  logic         clk_en = 1'b0;
  logic         reset_;
  logic         soc;
  logic [N-1:0] x, y;
  logic         cin;
  logic [N-1:0] s;
  logic         cout;
  logic         eoc;

  int n_pass = 0;
  int n_total = 0;

  b2_serial_adder #(.N(N)) dut (
    .clock(clock), .reset_(reset_), .soc(soc), .x(x), .y(y), .cin(cin),
    .s(s), .cout(cout), .eoc(eoc)
  );

  always #5 if (clk_en) clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One four-phase transaction; optionally scramble inputs during compute
  // and/or keep soc high after completion to confirm no retrigger.
  task automatic do_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [7:0] exp_s, input logic exp_c,
                        input bit scramble, input bit hold);
    int lowc;
    int retrig;
    @(negedge clock);
    x = a; y = b; cin = ci; soc = 1'b1;
    lowc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!eoc) begin
        lowc++;
        if (scramble) begin
          x = 8'($urandom); y = 8'($urandom); cin = 1'($urandom);
        end
      end else if (lowc > 0) break;
    end
    check({tag, "_busy_cycles"}, lowc, 8);
    check({tag, "_s"}, s, exp_s);
    check({tag, "_cout"}, cout, exp_c);
    if (hold) begin
      retrig = 0;
      repeat (20) begin
        @(negedge clock);
        if (!eoc) retrig++;
      end
      check({tag, "_hold_no_retrigger"}, retrig, 0);
      check({tag, "_hold_s"}, s, exp_s);
    end
    soc = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset_ = 1'b0; soc = 1'b0; x = '0; y = '0; cin = 1'b0;
    #3;
    check("rst_noclk_eoc", eoc, 1);
    check("rst_noclk_s", s, 0);
    check("rst_noclk_cout", cout, 0);

    clk_en = 1'b1;
    #12 reset_ = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_eoc", eoc, 1);
    check("idle_s", s, 0);
    check("idle_cout", cout, 0);

    do_add("add_5a_33",   8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b0, 1'b0);
    do_add("add_ff_00_c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    do_add("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
    do_add("add_01_01",   8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    do_add("add_scram",   8'hC7, 8'h6E, 1'b1, 8'h36, 1'b1, 1'b1, 1'b0);

    // Abort mid-computation with an asynchronous reset.
    @(negedge clock);
    x = 8'h77; y = 8'h11; cin = 1'b1; soc = 1'b1;
    repeat (4) @(negedge clock);
    check("abort_busy_before_rst", eoc, 0);
    #2 reset_ = 1'b0;
    #1;
    check("abort_eoc", eoc, 1);
    check("abort_s", s, 0);
    check("abort_cout", cout, 0);
    soc = 1'b0;
    @(negedge clock);
    reset_ = 1'b1;
    @(negedge clock);

    do_add("add_10_20",   8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
